// File: rtl/issue_age_sched.sv
// Issue-queue slot scheduler: slot allocation, operand wakeup and single-issue selection.
// Define ISSUE_AGE_SELECT_EN for oldest-first selection through an age matrix; otherwise lowest index wins.
module issue_age_sched #(
    parameter int NSLOT = 16,
    parameter int SW    = 4,
    parameter int TW    = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              alloc_req,
    input  logic [3*TW-1:0]   alloc_tags,
    input  logic [2:0]        alloc_busy,
    output logic              alloc_ok,
    output logic [SW-1:0]     alloc_slot,
    input  logic              wake_valid,
    input  logic [TW-1:0]     wake_tag,
    input  logic              exe_ready,
    output logic              issue_valid,
    output logic [SW-1:0]     issue_slot,
    output logic [SW:0]       occupancy,
    output logic              full,
    output logic              empty
);

    logic [NSLOT-1:0] valid_r;
    logic [2:0]       rdy_r [NSLOT];
    logic [TW-1:0]    tag_r [NSLOT][3];

    logic [NSLOT-1:0] elig_s;
    logic [NSLOT-1:0] grant_s;
    logic             grant_any_s;
    logic [SW-1:0]    grant_idx_s;
    logic             free_any_s;
    logic [SW-1:0]    free_idx_s;
    logic             alloc_fire_s;
    logic             issue_fire_s;
    logic [TW-1:0]    new_tag_s [3];
    logic [2:0]       alloc_rdy_s;
    logic [SW:0]      occ_next_s;

    logic             issue_valid_r;
    logic [SW-1:0]    issue_slot_r;
    logic [SW:0]      occ_r;
    logic             full_r;
    logic             empty_r;

    function automatic logic tag_hit(input logic [TW-1:0] tag, input logic wv, input logic [TW-1:0] wt);
        return wv && (tag != {TW{1'b0}}) && (tag == wt);
    endfunction

    // Lowest-index free slot search
    always_comb begin
        free_any_s = 1'b0;
        free_idx_s = {SW{1'b0}};
        for (int i = 0; i < NSLOT; i++) begin
            if (!valid_r[i] && !free_any_s) begin
                free_any_s = 1'b1;
                free_idx_s = SW'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Incoming tags and their ready bits, including a same-edge wake bypass
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            new_tag_s[k]   = alloc_tags[k*TW +: TW];
            alloc_rdy_s[k] = (new_tag_s[k] == {TW{1'b0}}) | !alloc_busy[k]
                             | tag_hit(new_tag_s[k], wake_valid, wake_tag);
        end
    end

    // Eligibility per slot
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            elig_s[i] = valid_r[i] & (&rdy_r[i]);
        end
    end

`ifdef ISSUE_AGE_SELECT_EN
    logic [NSLOT-1:0] older_r   [NSLOT];
    logic [NSLOT-1:0] older_t_s [NSLOT];

    // Transposed age matrix: older_t_s[i][j] means slot j is older than slot i
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            for (int j = 0; j < NSLOT; j++) begin
                older_t_s[i][j] = older_r[j][i];
            end
        end
    end

    // Oldest-first pick: an eligible slot wins when no eligible slot is older
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            grant_s[i] = elig_s[i] & ~(|(elig_s & older_t_s[i]));
        end
    end

    // Age matrix: a new entry becomes younger than every live entry; issue clears its column
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NSLOT; i++) older_r[i] <= {NSLOT{1'b0}};
        end else if (FLUSH) begin
            for (int i = 0; i < NSLOT; i++) older_r[i] <= {NSLOT{1'b0}};
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (alloc_fire_s && (free_idx_s == SW'(i))) begin
                    older_r[i] <= {NSLOT{1'b0}};
                end else begin
                    for (int j = 0; j < NSLOT; j++) begin
                        if (issue_fire_s && grant_s[j]) begin
                            older_r[i][j] <= 1'b0;
                        end else if (alloc_fire_s && (free_idx_s == SW'(j)) && valid_r[i]
                                     && !(issue_fire_s && grant_s[i])) begin
                            older_r[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
`else
    // Lowest-index pick: isolate the least-significant eligible bit
    always_comb begin
        grant_s = elig_s & (~elig_s + {{(NSLOT-1){1'b0}}, 1'b1});
    end
`endif

    // One-hot grant to index
    always_comb begin
        grant_any_s = |grant_s;
        grant_idx_s = {SW{1'b0}};
        for (int i = 0; i < NSLOT; i++) begin
            if (grant_s[i]) begin
                grant_idx_s = grant_idx_s | SW'(i);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Fire conditions and next occupancy
    always_comb begin
        alloc_ok     = free_any_s && !STALL && !FLUSH;
        alloc_slot   = free_idx_s;
        alloc_fire_s = alloc_req && alloc_ok;
        issue_fire_s = grant_any_s && exe_ready && !STALL && !FLUSH;
        occ_next_s   = occ_r + (SW+1)'(alloc_fire_s) - (SW+1)'(issue_fire_s);
    end

    // Slot valid, operand-ready and tag state; wakeups apply even while stalled
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_r <= {NSLOT{1'b0}};
            for (int i = 0; i < NSLOT; i++) begin
                rdy_r[i] <= 3'b000;
                for (int k = 0; k < 3; k++) tag_r[i][k] <= {TW{1'b0}};
            end
        end else if (FLUSH) begin
            valid_r <= {NSLOT{1'b0}};
            for (int i = 0; i < NSLOT; i++) rdy_r[i] <= 3'b000;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (valid_r[i] && tag_hit(tag_r[i][k], wake_valid, wake_tag)) begin
                        rdy_r[i][k] <= 1'b1;
                    end
                end
                if (alloc_fire_s && (free_idx_s == SW'(i))) begin
                    valid_r[i] <= 1'b1;
                    rdy_r[i]   <= alloc_rdy_s;
                    for (int k = 0; k < 3; k++) tag_r[i][k] <= new_tag_s[k];
                end else if (issue_fire_s && grant_s[i]) begin
                    valid_r[i] <= 1'b0;
                end
            end
        end
    end

    // Registered issue and occupancy outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            issue_valid_r <= 1'b0;
            issue_slot_r  <= {SW{1'b0}};
            occ_r         <= {(SW+1){1'b0}};
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
        end else if (FLUSH) begin
            issue_valid_r <= 1'b0;
            occ_r         <= {(SW+1){1'b0}};
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
        end else begin
            issue_valid_r <= issue_fire_s;
            if (issue_fire_s) issue_slot_r <= grant_idx_s;
            occ_r   <= occ_next_s;
            full_r  <= (occ_next_s == (SW+1)'(NSLOT));
            empty_r <= (occ_next_s == {(SW+1){1'b0}});
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_slot  = issue_slot_r;
    assign occupancy   = occ_r;
    assign full        = full_r;
    assign empty       = empty_r;

endmodule
